// File: rtl/video_pkg.sv
// Shared video definitions: default frame geometry, Wishbone cycle-type
// codes and the pixel reader FSM state type.
package video_pkg;

    localparam int unsigned DEF_HDISP = 800;
    localparam int unsigned DEF_VDISP = 480;

    typedef enum logic [2:0] {
        CLASSIC = 3'b000,
        INCR    = 3'b010,
        END     = 3'b111
    } cti_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } reader_state_t;

endpackage

// File: rtl/wshb_if.sv
// 32-bit Wishbone B4 bus bundle (byte addressing) with master/slave views.
interface wshb_if;

    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic [31:0] adr;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output dat_ms, adr, cyc, stb, we, sel, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  dat_ms, adr, cyc, stb, we, sel, cti, bte,
        output dat_sm, ack, err, rty
    );

endinterface

// File: rtl/frame_addr_counter.sv
// Wrapping up-counter (0 .. MODULUS-1) with synchronous clear, a mark
// register that snapshots the current count, and rewind back to that mark.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   clr_i         clear count and mark to zero
//   inc_i         advance by one, wrapping MODULUS-1 -> 0
//   mark_i        remember the current count
//   rewind_i      reload the remembered count (wins over inc_i)
//   cnt_o         current count
module frame_addr_counter #(
    parameter int unsigned MODULUS = 8,
    parameter int unsigned WIDTH   = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             mark_i,
    input  logic             rewind_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mark_q, mark_d;

    always_comb begin
        cnt_d  = cnt_q;
        mark_d = mark_q;
        if (clr_i) begin
            cnt_d  = '0;
            mark_d = '0;
        end else begin
            if (rewind_i) begin
                cnt_d = mark_q;
            end else if (inc_i) begin
                cnt_d = (cnt_q == WIDTH'(MODULUS - 1)) ? '0 : cnt_q + 1'b1;
            end
            if (mark_i) begin
                mark_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            mark_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            mark_q <= mark_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/wshb_pixel_reader.sv
// Wishbone read master that streams the frame buffer linearly from
// address 0 (wrapping forever) into the video FIFO write port.
// Ports:
//   sys_clk, sys_rst    system clock, synchronous active-high reset
//   wshb_ifm            Wishbone master to SDRAM (read-only, sel = 4'hF)
//   fifo_wdata          pixel word, valid while fifo_write is high
//   fifo_write          one-cycle write strobe, the cycle after each ack
//   fifo_wfull          FIFO full, start gate in the single-read build
//   fifo_walmost_full   fewer than BURST_LEN free slots, burst start gate
// Build option: define PIXEL_READER_BURST_EN for incrementing bursts of
// BURST_LEN beats; otherwise classic single reads are issued.
module wshb_pixel_reader
    import video_pkg::*;
#(
    parameter int unsigned HDISP     = DEF_HDISP,
    parameter int unsigned VDISP     = DEF_VDISP,
    parameter int unsigned BURST_LEN = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    wshb_if.master      wshb_ifm,
    output logic [31:0] fifo_wdata,
    output logic        fifo_write,
    input  logic        fifo_wfull,
    input  logic        fifo_walmost_full
);

    localparam int unsigned FRAME_WORDS = HDISP * VDISP;
    localparam int unsigned PIX_W       = $clog2(FRAME_WORDS);

    reader_state_t  state_q, state_d;
    logic [PIX_W-1:0] pix_cnt;
    logic           in_req;
    logic           start;
    logic           bus_fail;
    logic           ack_ok;
    logic           last_beat;
    logic           fifo_write_q;
    logic [31:0]    fifo_wdata_q;

    assign in_req   = (state_q == REQ);
    // An ack that coincides with err/rty is treated as a failed beat.
    assign bus_fail = wshb_ifm.err | wshb_ifm.rty;
    assign ack_ok   = wshb_ifm.ack & ~bus_fail;

`ifdef PIXEL_READER_BURST_EN
    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    logic [BEAT_W-1:0] beat_cnt;

    assign start     = ~fifo_walmost_full;
    assign last_beat = (beat_cnt == BEAT_W'(BURST_LEN - 1));

    frame_addr_counter #(
        .MODULUS (BURST_LEN),
        .WIDTH   (BEAT_W)
    ) u_beat_cnt (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
        .clr_i    ((~in_req & start) | (in_req & bus_fail)),
        .inc_i    (in_req & ack_ok),
        .mark_i   (1'b0),
        .rewind_i (1'b0),
        .cnt_o    (beat_cnt)
    );

    assign wshb_ifm.cti = in_req ? (last_beat ? END : INCR) : CLASSIC;
`else
    logic unused_almost_full;

    assign unused_almost_full = fifo_walmost_full;
    assign start              = ~fifo_wfull;
    assign last_beat          = 1'b1;
    assign wshb_ifm.cti       = CLASSIC;
`endif

    // Marking at request start lets a failed transfer (a whole burst in the
    // burst build) restart from its first word.
    frame_addr_counter #(
        .MODULUS (FRAME_WORDS),
        .WIDTH   (PIX_W)
    ) u_pix_cnt (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
        .clr_i    (1'b0),
        .inc_i    (in_req & ack_ok),
        .mark_i   (~in_req & start),
        .rewind_i (in_req & bus_fail),
        .cnt_o    (pix_cnt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus_fail) begin
                    state_d = IDLE;
                end else if (wshb_ifm.ack && last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            fifo_write_q <= 1'b0;
            fifo_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            fifo_write_q <= in_req & ack_ok;
            if (in_req && ack_ok) begin
                fifo_wdata_q <= wshb_ifm.dat_sm;
            end
        end
    end

    assign wshb_ifm.cyc    = in_req;
    assign wshb_ifm.stb    = in_req;
    assign wshb_ifm.we     = 1'b0;
    assign wshb_ifm.sel    = 4'hF;
    assign wshb_ifm.bte    = 2'b00;
    assign wshb_ifm.dat_ms = '0;
    assign wshb_ifm.adr    = 32'({pix_cnt, 2'b00});

    assign fifo_write = fifo_write_q;
    assign fifo_wdata = fifo_wdata_q;

endmodule

// File: tb/tb_wshb_pixel_reader.sv
module tb_wshb_pixel_reader;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [31:0] fifo_wdata;
    logic        fifo_write;
    logic        fifo_wfull = 1'b0;
    logic        fifo_walmost_full = 1'b0;

    logic ack_en   = 1'b0;
    logic err_en   = 1'b0;
    logic late_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    logic [31:0] wlog[$];
    int          tlog[$];

    wshb_if ifm ();

    // Zero-wait slave returning the address as data.
    assign ifm.dat_sm = ifm.adr;
    assign ifm.ack    = (ifm.cyc & ifm.stb & ack_en) | late_ack;
    assign ifm.err    = ifm.cyc & ifm.stb & err_en & (ifm.adr == 32'h8);
    assign ifm.rty    = 1'b0;

    wshb_pixel_reader #(
        .HDISP     (4),
        .VDISP     (2),
        .BURST_LEN (4)
    ) dut (
        .sys_clk           (sys_clk),
        .sys_rst           (sys_rst),
        .wshb_ifm          (ifm.master),
        .fifo_wdata        (fifo_wdata),
        .fifo_write        (fifo_write),
        .fifo_wfull        (fifo_wfull),
        .fifo_walmost_full (fifo_walmost_full)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc_n++;
        if (fifo_write === 1'b1) begin
            wlog.push_back(fifo_wdata);
            tlog.push_back(cyc_n);
        end
    endtask

    task automatic wait_req_at(input logic [31:0] a, input string tag);
        int n;
        n = 0;
        while (!(ifm.stb === 1'b1 && ifm.adr === a) && n < 60) begin
            tick();
            n++;
        end
        check(tag, {31'b0, ifm.stb === 1'b1 && ifm.adr === a}, 32'h1);
    endtask

    initial begin
        // Reset: outputs at their reset values while held.
        repeat (3) tick();
        check("rst_cyc_stb", {30'b0, ifm.cyc, ifm.stb}, 32'h0);
        check("rst_we", {31'b0, ifm.we}, 32'h0);
        check("rst_adr", ifm.adr, 32'h0);
        check("rst_cti_bte", {27'b0, ifm.cti, ifm.bte}, 32'h0);
        check("rst_fifo", {31'b0, fifo_write}, 32'h0);
        check("rst_wdata", fifo_wdata, 32'h0);
        sys_rst = 1'b0;
        tick();
        check("start_stb", {31'b0, ifm.stb}, 32'h1);
        check("start_adr", ifm.adr, 32'h0);
        check("start_sel", {28'b0, ifm.sel}, 32'hF);
        ack_en = 1'b1;

`ifdef PIXEL_READER_BURST_EN
        for (int b = 0; b < 4; b++) begin
            check($sformatf("burst_cti%0d", b), {29'b0, ifm.cti}, (b == 3) ? 32'h7 : 32'h2);
            check($sformatf("burst_adr%0d", b), ifm.adr, 32'(b * 4));
            tick();
            check($sformatf("burst_wr%0d", b), {31'b0, fifo_write}, 32'h1);
            check($sformatf("burst_wdata%0d", b), fifo_wdata, 32'(b * 4));
        end
        fifo_walmost_full = 1'b1;
        check("burst_end_cyc", {31'b0, ifm.cyc}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("burst_gate%0d", i), {31'b0, ifm.cyc}, 32'h0);
        end
        fifo_walmost_full = 1'b0;
        tick();
        check("burst2_stb", {31'b0, ifm.stb}, 32'h1);
        check("burst2_adr", ifm.adr, 32'h10);
        check("burst2_cti", {29'b0, ifm.cti}, 32'h2);
`else
        // Full frame: 20 words, wrap after 8, one IDLE cycle between words.
        for (int n = 0; n < 100 && wlog.size() < 20; n++) tick();
        fifo_wfull = 1'b1;
        check("frame_count", 32'(wlog.size()), 32'd20);
        for (int i = 0; i < wlog.size(); i++) begin
            check($sformatf("frame_word%0d", i), wlog[i], 32'((i % 8) * 4));
            if (i > 0) check($sformatf("frame_gap%0d", i), 32'(tlog[i] - tlog[i-1]), 32'd2);
        end
        tick();
        check("frame_stop", {30'b0, ifm.cyc, fifo_write}, 32'h0);

        // Backpressure after word 3.
        sys_rst = 1'b1;
        tick();
        tick();
        fifo_wfull = 1'b0;
        sys_rst = 1'b0;
        wlog.delete();
        tlog.delete();
        for (int n = 0; n < 40 && wlog.size() < 3; n++) tick();
        fifo_wfull = 1'b1;
        check("bp_count", 32'(wlog.size()), 32'd3);
        for (int i = 0; i < wlog.size(); i++) check($sformatf("bp_word%0d", i), wlog[i], 32'(i * 4));
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold%0d", i), {30'b0, ifm.cyc, fifo_write}, 32'h0);
        end
        fifo_wfull = 1'b0;
        tick();
        check("bp_resume_stb", {31'b0, ifm.stb}, 32'h1);
        check("bp_resume_adr", ifm.adr, 32'hC);
        tick();
        check("bp_resume_wr", {31'b0, fifo_write}, 32'h1);
        check("bp_resume_data", fifo_wdata, 32'hC);

        // Error retry on adr 0x8 (ack and err together -> error).
        err_en = 1'b1;
        wait_req_at(32'h8, "err_reach");
        tick();
        check("err_nowrite", {31'b0, fifo_write}, 32'h0);
        check("err_idle", {31'b0, ifm.stb}, 32'h0);
        err_en = 1'b0;
        tick();
        check("err_retry_stb", {31'b0, ifm.stb}, 32'h1);
        check("err_retry_adr", ifm.adr, 32'h8);
        tick();
        check("err_retry_wr", {31'b0, fifo_write}, 32'h1);
        check("err_retry_data", fifo_wdata, 32'h8);

        // Reset while stalled at adr 0x14, with a late ack.
        wait_req_at(32'h14, "mid_reach");
        ack_en = 1'b0;
        tick();
        check("mid_stall", {ifm.stb, ifm.adr[30:0]}, 32'h8000_0014);
        sys_rst  = 1'b1;
        late_ack = 1'b1;
        tick();
        check("mid_rst_stb", {30'b0, ifm.cyc, ifm.stb}, 32'h0);
        check("mid_rst_adr", ifm.adr, 32'h0);
        check("mid_rst_wr", {31'b0, fifo_write}, 32'h0);
        tick();
        sys_rst = 1'b0;
        tick();
        check("mid_late_ack", {31'b0, fifo_write}, 32'h0);
        check("mid_restart", {ifm.stb, ifm.adr[30:0]}, 32'h8000_0000);
        late_ack = 1'b0;
        ack_en   = 1'b1;
        tick();
        check("mid_restart_wr", {31'b0, fifo_write}, 32'h1);
        check("mid_restart_data", fifo_wdata, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wshb_pixel_reader.md
# wshb_pixel_reader

Wishbone read master that streams the frame buffer out of SDRAM and pushes each 32-bit pixel word into the write port of the video FIFO, which the VGA controller drains on the pixel clock side. Sits on the system clock domain as master of `wshb_if_sdram` (replacing the current tie-offs in `Top`), directly upstream of that FIFO. Reads the frame linearly from address 0 and wraps forever, one word per pixel.

## Interface
Parameters:
- `HDISP`, 800, active pixels per line
- `VDISP`, 480, active lines per frame
- `BURST_LEN`, 8, words per Wishbone burst (burst build only); must divide `HDISP*VDISP`

Ports:
- `sys_clk`  in  1  system clock, 100 MHz; the only clock
- `sys_rst`  in  1  synchronous, active-high reset
- `wshb_ifm`  `wshb_if.master`  —  32-bit Wishbone master to SDRAM; byte address `adr`, `sel` = 4'hF, `we` = 0
- `fifo_wdata`  out  32  pixel word to FIFO
- `fifo_write`  out  1  FIFO write strobe, one word per high cycle
- `fifo_wfull`  in  1  FIFO full
- `fifo_walmost_full`  in  1  fewer than `BURST_LEN` free slots (burst build only)

## Operation
- Word counter `pix_cnt`, range 0 .. `HDISP*VDISP-1`, width `$clog2(HDISP*VDISP)`; `adr = {pix_cnt, 2'b00}` zero-extended to bus width.
- FSM states: `IDLE`, `REQ`.
- `IDLE`: `cyc = stb = 0`. Go to `REQ` when start condition holds (`!fifo_wfull`; burst build: `!fifo_walmost_full`).
- `REQ`: `cyc = stb = 1`, `adr` from `pix_cnt`.
  - `ack`: `fifo_wdata <= dat_sm`, `fifo_write <= 1` for one cycle; `pix_cnt` increments, wrapping `HDISP*VDISP-1 -> 0`. Single build: return to `IDLE`. Burst build: stay in `REQ` until the last beat, then `IDLE`.
  - `err` or `rty`: no FIFO write, `pix_cnt` unchanged (burst: rewinds to burst start), return to `IDLE`; request reissued from `IDLE`.
  - `ack` together with `err`/`rty`: treat as error.
- `fifo_write` is never asserted except in the cycle after an `ack`. FIFO overflow is impossible by construction; `fifo_wfull` is sampled only in `IDLE`.
- Reset mid-cycle: `cyc`/`stb` drop on the next edge; any pending `ack` is ignored; reading restarts at address 0.

## Timing
- Reset values: `cyc = 0`, `stb = 0`, `we = 0`, `adr = 0`, `cti = 0`, `bte = 0`, `fifo_write = 0`, `fifo_wdata = 0`, state `IDLE`, `pix_cnt = 0`.
- `IDLE -> REQ`: 1 cycle. `stb` rises on the edge after the start condition is seen.
- `ack` at edge N: `fifo_write` is high during cycle N+1, with `fifo_wdata` valid.
- Single build: at most one word per 2 cycles plus slave latency. `stb` deasserts on the edge that samples `ack`.
- Burst build: `stb` stays high across beats. `adr` advances on each `ack`. The last beat presents `cti = 3'b111`.

## Configuration
- `PIXEL_READER_BURST_EN` defined:
  - Incrementing bursts of `BURST_LEN` beats.
  - `cti = 3'b010` on all beats except the last, which uses `3'b111`; `bte = 2'b00`.
  - Start gated by `fifo_walmost_full`.
  - Bursts never cross the frame wrap, since `BURST_LEN` divides the frame size.
- Undefined: classic single reads (`cti = 3'b000`), start gated by `fifo_wfull`, and `fifo_walmost_full` is ignored.

## Structure
- Package `video_pkg`:
  - `cti_t` constants: CLASSIC, INCR, END.
  - `reader_state_t` enum: `IDLE`, `REQ`.
  - Default `HDISP`/`VDISP` localparams shared with the VGA controller.
- Sub-module `frame_addr_counter`: a wrapping counter with increment, rewind-to-mark, and sync clear. It is used for `pix_cnt`, and also for the beat count in the burst build.

## Test plan
Common bench setup: `HDISP=4`, `VDISP=2`; the Wishbone slave model returns `dat_sm = adr`.
- **Reset:** hold `sys_rst` high for 3 cycles, then release with the FIFO empty. Expect `stb` high 1 cycle after release, with `adr = 0`.
- **Full frame:** use a zero-wait slave and run 20 words. Expect `fifo_wdata` to sequence 0x0, 0x4, …, 0x1C, then 0x0 again (wrap after 8 words). Expect no gap other than the IDLE cycle.
- **Backpressure:** force `fifo_wfull = 1` after word 3. Expect `cyc` low and no `fifo_write` while full. After release, the next read is `adr = 0xC`.
- **Error retry:** assert `err` on the read of `adr = 0x8`. Expect no write. Expect the next request to use `adr = 0x8`, and the stream to continue with 0x8.
- **Reset mid-cycle:** raise `sys_rst` while `stb` is high at `adr = 0x14`. Expect `stb = 0` on the next edge, a late `ack` to be ignored, and the restart to use `adr = 0`.
- **Burst build** (`BURST_LEN=4`): expect 4 beats with `cti` = 010, 010, 010, 111 at `adr` 0x0–0xC. The next burst must not start while `fifo_walmost_full = 1`.
